// File: rtl/weight_fetch_unit_pkg.sv
// Shared definitions for the weight fetch path: FSM encoding and the
// load-phase bit positions agreed with the weight pipeline controller.
package weight_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } wfu_state_e;

  localparam int LOAD_BIT  = 0;
  localparam int LAYER_BIT = 1;

endpackage

// File: rtl/weight_fetch_unit_lowest_set_bit.sv
// Priority scan: reports the index of the lowest set bit of a mask and
// whether any bit is set at all.
module lowest_set_bit #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  always_comb begin
    index = '0;
    // Scan downwards so the lowest set bit is the last one to win.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
      end
    end
    any = |mask;
  end

endmodule

// File: rtl/weight_fetch_unit.sv
// Fetches one weight per enabled MAC lane from a synchronous memory, one
// lane per cycle lowest first, and holds them in per-lane registers.
module weight_fetch_unit
  import weight_fetch_unit_pkg::*;
#(
  parameter int N_MACS = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               load,
  input  logic [N_MACS-1:0]        weight_ctrl,
  input  logic [ADDR_W-1:0]        load_base,
  input  logic [ADDR_W-1:0]        layer_base,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic [N_MACS*DATA_W-1:0] w_out,
  output logic [N_MACS-1:0]        w_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IDX_W = (N_MACS > 1) ? $clog2(N_MACS) : 1;

  wfu_state_e        state_q, state_d;
  logic [N_MACS-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              pend_q, pend_d;
  logic [IDX_W-1:0]  lane_q, lane_d;
  logic [DATA_W-1:0] w_q [N_MACS];
  logic [DATA_W-1:0] w_d [N_MACS];
  logic [N_MACS-1:0] w_valid_q, w_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  scan_idx;
  logic              scan_any;
  logic [N_MACS-1:0] scan_onehot;
  logic              load_req;
  logic              load_unused;

  lowest_set_bit #(
    .N (N_MACS)
  ) u_scan (
    .mask  (mask_q),
    .index (scan_idx),
    .any   (scan_any)
  );

  assign load_req    = load[LOAD_BIT] | load[LAYER_BIT];
  assign load_unused = load[2];
  assign scan_onehot = N_MACS'(1) << scan_idx;

  assign mem_rd_en = (state_q == ST_FETCH) && scan_any;
  assign mem_addr  = mem_rd_en ? ADDR_W'(base_q + ADDR_W'(scan_idx)) : '0;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    base_d    = base_q;
    pend_d    = 1'b0;
    lane_d    = lane_q;
    w_d       = w_q;
    w_valid_d = w_valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // Read issued last cycle: its data is on mem_rd_data now.
    for (int i = 0; i < N_MACS; i++) begin
      if (pend_q && (lane_q == IDX_W'(i))) begin
        w_d[i]       = mem_rd_data;
        w_valid_d[i] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          mask_d    = weight_ctrl;
          base_d    = load[LOAD_BIT] ? load_base : layer_base;
          w_valid_d = w_valid_q & ~weight_ctrl;
          state_d   = (|weight_ctrl) ? ST_FETCH : ST_DRAIN;
        end
      end
      ST_FETCH: begin
        err_d = load_req;
        if (scan_any) begin
          mask_d = mask_q & ~scan_onehot;
          pend_d = 1'b1;
          lane_d = scan_idx;
        end
        if (mask_d == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        err_d   = load_req;
        done_d  = 1'b1;
        mask_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        mask_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      base_q    <= '0;
      pend_q    <= 1'b0;
      lane_q    <= '0;
      w_valid_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < N_MACS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      base_q    <= base_d;
      pend_q    <= pend_d;
      lane_q    <= lane_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      for (int i = 0; i < N_MACS; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < N_MACS; gi++) begin : g_lane
    assign w_out[gi*DATA_W +: DATA_W] = w_q[gi];
  end

  assign w_valid = w_valid_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed bench for weight_fetch_unit: a synchronous memory model returns
// 8'hA0 + address, and each pass is checked cycle by cycle.
module tb_weight_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  load;
  logic [3:0]  weight_ctrl;
  logic [7:0]  load_base;
  logic [7:0]  layer_base;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic [31:0] w_out;
  logic [3:0]  w_valid;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks;
  int n_pass;
  int done_seen;

  weight_fetch_unit #(
    .N_MACS (4),
    .DATA_W (8),
    .ADDR_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .weight_ctrl (weight_ctrl),
    .load_base   (load_base),
    .layer_base  (layer_base),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .w_out       (w_out),
    .w_valid     (w_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: one-cycle read latency.
  initial mem_rd_data = 8'h00;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'hA0 + mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] ld, input logic [3:0] msk,
                       input logic [7:0] lb, input logic [7:0] yb);
    load        = ld;
    weight_ctrl = msk;
    load_base   = lb;
    layer_base  = yb;
    $display("pass: load=%b mask=%b load_base=%h layer_base=%h", ld, msk, lb, yb);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    load        = 3'b000;
    weight_ctrl = 4'b0000;
    load_base   = 8'h00;
    layer_base  = 8'h00;
    tick();
    tick();
    check("rst_w_out",   w_out, 32'h0);
    check("rst_w_valid", {28'h0, w_valid}, 32'h0);
    check("rst_busy",    {31'h0, busy}, 32'h0);
    check("rst_done",    {31'h0, done}, 32'h0);
    check("rst_err",     {31'h0, err}, 32'h0);
    check("rst_rd_en",   {31'h0, mem_rd_en}, 32'h0);
    check("rst_addr",    {24'h0, mem_addr}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Pass 1: load phase, lanes 0/1 from 0x10.
    start(3'b001, 4'b0011, 8'h10, 8'h99);
    tick();
    load = 3'b000;
    check("p1_t1_rd_en", {31'h0, mem_rd_en}, 32'h1);
    check("p1_t1_addr",  {24'h0, mem_addr}, 32'h10);
    check("p1_t1_busy",  {31'h0, busy}, 32'h1);
    tick();
    check("p1_t2_addr",  {24'h0, mem_addr}, 32'h11);
    tick();
    check("p1_t3_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("p1_t3_busy",  {31'h0, busy}, 32'h1);
    check("p1_t3_done",  {31'h0, done}, 32'h0);
    tick();
    check("p1_t4_done",  {31'h0, done}, 32'h1);
    check("p1_t4_busy",  {31'h0, busy}, 32'h0);
    check("p1_t4_valid", {28'h0, w_valid}, 32'h3);
    check("p1_t4_w_out", w_out, 32'h0000B1B0);

    // Pass 2: accepted in the done cycle; layer base wraps past 0xFF.
    start(3'b010, 4'b1100, 8'h55, 8'hFE);
    tick();
    load = 3'b000;
    check("p2_t1_addr",  {24'h0, mem_addr}, 32'h00);
    check("p2_t1_valid", {28'h0, w_valid}, 32'h3);
    tick();
    check("p2_t2_addr",  {24'h0, mem_addr}, 32'h01);
    tick();
    tick();
    check("p2_t4_done",  {31'h0, done}, 32'h1);
    check("p2_t4_valid", {28'h0, w_valid}, 32'hF);
    check("p2_t4_w_out", w_out, 32'hA1A0B1B0);

    // Pass 3: both phase bits set, load_base wins.
    start(3'b011, 4'b0101, 8'h20, 8'h50);
    tick();
    load = 3'b000;
    check("p3_t1_addr",  {24'h0, mem_addr}, 32'h20);
    check("p3_t1_valid", {28'h0, w_valid}, 32'hA);
    tick();
    check("p3_t2_addr",  {24'h0, mem_addr}, 32'h22);
    tick();
    check("p3_t3_done",  {31'h0, done}, 32'h0);
    tick();
    check("p3_t4_done",  {31'h0, done}, 32'h1);
    check("p3_t4_w_out", w_out, 32'hA1C2B1C0);

    // Pass 4: empty mask.
    start(3'b001, 4'b0000, 8'h77, 8'h88);
    tick();
    load = 3'b000;
    check("p4_t1_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("p4_t1_busy",  {31'h0, busy}, 32'h1);
    check("p4_t1_done",  {31'h0, done}, 32'h0);
    tick();
    check("p4_t2_done",  {31'h0, done}, 32'h1);
    check("p4_t2_busy",  {31'h0, busy}, 32'h0);

    // Pass 5: second load while busy is rejected with err.
    start(3'b001, 4'b0011, 8'h30, 8'h66);
    tick();
    check("p5_t1_addr",  {24'h0, mem_addr}, 32'h30);
    start(3'b010, 4'b1111, 8'h44, 8'h70);
    tick();
    load = 3'b000;
    check("p5_t2_err",   {31'h0, err}, 32'h1);
    check("p5_t2_addr",  {24'h0, mem_addr}, 32'h31);
    tick();
    check("p5_t3_err",   {31'h0, err}, 32'h0);
    check("p5_t3_rd_en", {31'h0, mem_rd_en}, 32'h0);
    tick();
    check("p5_t4_done",  {31'h0, done}, 32'h1);
    check("p5_t4_valid", {28'h0, w_valid}, 32'hF);
    check("p5_t4_w_out", w_out, 32'hA1C2D1D0);

    // Pass 6: reset asserted in T+2 of a 4-lane pass.
    start(3'b001, 4'b1111, 8'h40, 8'h00);
    tick();
    load = 3'b000;
    check("p6_t1_addr",  {24'h0, mem_addr}, 32'h40);
    tick();
    rst_n = 1'b0;
    #1;
    check("p6_rst_valid", {28'h0, w_valid}, 32'h0);
    check("p6_rst_w_out", w_out, 32'h0);
    check("p6_rst_busy",  {31'h0, busy}, 32'h0);
    check("p6_rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("p6_no_done",     done_seen, 0);
    check("p6_after_w_out", w_out, 32'h0);
    check("p6_after_valid", {28'h0, w_valid}, 32'h0);

    // Pass 7: fresh pass after the abort.
    start(3'b001, 4'b1001, 8'h50, 8'h00);
    tick();
    load = 3'b000;
    check("p7_t1_addr",  {24'h0, mem_addr}, 32'h50);
    tick();
    check("p7_t2_addr",  {24'h0, mem_addr}, 32'h53);
    tick();
    tick();
    check("p7_t4_done",  {31'h0, done}, 32'h1);
    check("p7_t4_valid", {28'h0, w_valid}, 32'h9);
    check("p7_t4_w_out", w_out, 32'hF30000F0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
